// File: rtl/mmio_port_responder.sv
// Memory-mapped port/timer responder on the data-memory bus: PORTOUT, synchronized PORTIN with
// rising-edge flags, a reloadable down-counter and a level Irq. Optional macro: MMIO_PORTOUT_SETCLR_EN.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR     = 32'hFFFF_0000,
  parameter int unsigned PORT_IN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [31:0]              Address,
  input  logic [31:0]              WriteData,
  output logic [31:0]              ReadData,
  output logic                     Hit,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic [31:0]              PortOut,
  output logic                     Irq
);

  localparam int unsigned PW = PORT_IN_WIDTH;

  localparam logic [3:0] OFF_PORTOUT = 4'h0;
  localparam logic [3:0] OFF_PORTIN  = 4'h1;
  localparam logic [3:0] OFF_EDGE    = 4'h2;
  localparam logic [3:0] OFF_EDGE_EN = 4'h3;
  localparam logic [3:0] OFF_TCOUNT  = 4'h4;
  localparam logic [3:0] OFF_TCTRL   = 4'h5;
  localparam logic [3:0] OFF_TRELOAD = 4'h6;
`ifdef MMIO_PORTOUT_SETCLR_EN
  localparam logic [3:0] OFF_PORTSET = 4'h7;
  localparam logic [3:0] OFF_PORTCLR = 4'h8;
`endif

  logic [31:0]   r_portout;
  logic [PW-1:0] r_s1, r_s2, r_prev;
  logic [PW-1:0] r_edge, r_edge_en;
  logic [31:0]   r_tcount, r_treload;
  logic          r_en, r_auto, r_exp, r_tie;

  logic [3:0]    w_off;
  logic          w_wr, w_rd;
  logic [PW-1:0] w_rise;
  logic          w_expire;

  logic [31:0]   w_portout_nxt, w_tcount_nxt, w_treload_nxt;
  logic [PW-1:0] w_edge_nxt, w_edge_en_nxt;
  logic          w_en_nxt, w_auto_nxt, w_exp_nxt, w_tie_nxt;

  logic          w_unused;

  assign w_off    = Address[5:2];
  assign Hit      = (Address[31:6] == BASE_ADDR[31:6]);
  assign w_wr     = MemWrite & Hit;
  assign w_rd     = MemRead & Hit;
  assign w_rise   = r_s2 & ~r_prev;
  assign w_unused = ^Address[1:0];

  assign PortOut  = r_portout;
  assign Irq      = (|(r_edge & r_edge_en)) | (r_exp & r_tie);

  // Zero-wait read mux; shows pre-write values on a simultaneous read/write
  always_comb begin
    ReadData = 32'd0;
    if (w_rd) begin
      case (w_off)
        OFF_PORTOUT: ReadData = r_portout;
        OFF_PORTIN:  ReadData = 32'(r_s2);
        OFF_EDGE:    ReadData = 32'(r_edge);
        OFF_EDGE_EN: ReadData = 32'(r_edge_en);
        OFF_TCOUNT:  ReadData = r_tcount;
        OFF_TCTRL:   ReadData = {28'd0, r_tie, r_exp, r_auto, r_en};
        OFF_TRELOAD: ReadData = r_treload;
        default:     ReadData = 32'd0;
      endcase
    end
  end

  // Next-state: bus writes first, then internal events (rise, expiry) take precedence
  always_comb begin
    w_portout_nxt = r_portout;
    w_edge_nxt    = r_edge;
    w_edge_en_nxt = r_edge_en;
    w_tcount_nxt  = r_tcount;
    w_treload_nxt = r_treload;
    w_en_nxt      = r_en;
    w_auto_nxt    = r_auto;
    w_exp_nxt     = r_exp;
    w_tie_nxt     = r_tie;
    w_expire      = 1'b0;

    if (w_wr) begin
      case (w_off)
        OFF_PORTOUT: w_portout_nxt = WriteData;
        OFF_EDGE:    w_edge_nxt    = r_edge & ~PW'(WriteData);
        OFF_EDGE_EN: w_edge_en_nxt = PW'(WriteData);
        OFF_TCTRL: begin
          w_en_nxt   = WriteData[0];
          w_auto_nxt = WriteData[1];
          w_tie_nxt  = WriteData[3];
          if (WriteData[2]) w_exp_nxt = 1'b0;
        end
        OFF_TRELOAD: w_treload_nxt = WriteData;
`ifdef MMIO_PORTOUT_SETCLR_EN
        OFF_PORTSET: w_portout_nxt = r_portout | WriteData;
        OFF_PORTCLR: w_portout_nxt = r_portout & ~WriteData;
`endif
        default: ;
      endcase
    end

    w_edge_nxt = w_edge_nxt | w_rise;

    if (w_wr && (w_off == OFF_TCOUNT)) begin
      w_tcount_nxt = WriteData;
    end else if (r_en && (r_tcount == 32'd0)) begin
      w_expire = 1'b1;
      if (r_auto) w_tcount_nxt = r_treload;
      else        w_en_nxt     = 1'b0;
    end else if (r_en) begin
      w_tcount_nxt = r_tcount - 32'd1;
    end

    if (w_expire) w_exp_nxt = 1'b1;
  end

  // State registers, including the PortIn synchronizer chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_portout <= 32'd0;
      r_s1      <= '0;
      r_s2      <= '0;
      r_prev    <= '0;
      r_edge    <= '0;
      r_edge_en <= '0;
      r_tcount  <= 32'd0;
      r_treload <= 32'd0;
      r_en      <= 1'b0;
      r_auto    <= 1'b0;
      r_exp     <= 1'b0;
      r_tie     <= 1'b0;
    end else begin
      r_portout <= w_portout_nxt;
      r_s1      <= PortIn;
      r_s2      <= r_s1;
      r_prev    <= r_s2;
      r_edge    <= w_edge_nxt;
      r_edge_en <= w_edge_en_nxt;
      r_tcount  <= w_tcount_nxt;
      r_treload <= w_treload_nxt;
      r_en      <= w_en_nxt;
      r_auto    <= w_auto_nxt;
      r_exp     <= w_exp_nxt;
      r_tie     <= w_tie_nxt;
    end
  end

endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor's data-memory bus, the target side of the MEM-stage MemRead/MemWrite/Address/WriteData initiator.
- Owns the processor's PortOut register and synchronizes PortIn. Detects rising edges on PortIn and provides a reloadable down-counter timer.
- Raises a level interrupt when an enabled event is pending.
- Sits beside DataMemory. The top level selects between this block's ReadData and DataMemory's ReadData using Hit.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, byte base address of the 64-byte register window; bits [5:0] must be 0.
- PORT_IN_WIDTH, 8, width of PortIn.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- MemRead  input  1  read strobe from MEM stage
- MemWrite  input  1  write strobe from MEM stage
- Address  input  32  byte address
- WriteData  input  32  write data
- ReadData  output  32  read data, combinational
- Hit  output  1  Address[31:6] == BASE_ADDR[31:6]
- PortIn  input  PORT_IN_WIDTH  external asynchronous inputs
- PortOut  output  32  PORTOUT register value
- Irq  output  1  interrupt request, level

Behaviour:
- Decode and access rules:
  - Offset is Address[5:2]; Address[1:0] is ignored.
  - Writes commit on the rising clk edge when MemWrite & Hit.
  - Reads are combinational, zero wait states; the pipeline has no stall.
  - ReadData = 0 when !(MemRead & Hit).
  - Unmapped offsets read 0 and ignore writes.
  - MemRead & MemWrite together: the write commits; ReadData shows the pre-write value.
- Register map (word offset, access):
  - 0x00 PORTOUT, R/W, 32 bits.
  - 0x04 PORTIN, R, zero-extended synchronized input.
  - 0x08 EDGE, R/W1C, [PORT_IN_WIDTH-1:0].
  - 0x0C EDGE_EN, R/W, [PORT_IN_WIDTH-1:0].
  - 0x10 TCOUNT, R/W, 32 bits.
  - 0x14 TCTRL: bit0 EN (R/W), bit1 AUTO (R/W), bit2 EXP (R/W1C), bit3 TIE (R/W).
  - 0x18 TRELOAD, R/W, 32 bits.
- Reset (reset=0, asynchronous):
  - Every register, the sync flops and the previous-sample flop go to 0.
  - Hence PortOut=0, Irq=0, ReadData=0.
- PortIn path:
  - Two-flop synchronizer (s1, s2), then prev <= s2.
  - PORTIN = s2, i.e. 2-cycle latency.
  - rise = s2 & ~prev; EDGE[i] sets on the edge after rise[i], so the flag is visible 3 cycles after PortIn rises.
  - PortIn already high at reset release sets EDGE, because prev resets to 0.
  - A new rise and a W1C of the same bit in the same cycle: set wins.
- Timer, per cycle in priority order:
  1. Write to TCOUNT loads WriteData; this overrides counting.
  2. Else if EN & TCOUNT==0: EXP<=1. If AUTO, TCOUNT<=TRELOAD; else EN<=0.
  3. Else if EN: TCOUNT<=TCOUNT-1.
  - TCOUNT never wraps below 0.
  - EXP set and W1C of EXP in the same cycle: set wins.
  - A write to TCTRL updates EN, AUTO and TIE, then rule 2 may still clear EN in that cycle: the internal update wins.
- Irq = |(EDGE & EDGE_EN) | (EXP & TIE), registered-source combinational. Irq deasserts the cycle after the clearing write.
- Reset mid-operation: asynchronous clear of all state; no partial write survives.

Optional Feature:
- Macro: MMIO_PORTOUT_SETCLR_EN.
- When defined:
  - Offset 0x1C PORTSET, W: PORTOUT <= PORTOUT | WriteData.
  - Offset 0x20 PORTCLR, W: PORTOUT <= PORTOUT & ~WriteData.
  - Both read 0.
- When undefined: 0x1C and 0x20 are unmapped (read 0, writes ignored).

Test Plan:
- Reset, then write 0x00 with 0xDEADBEEF at Address 0xFFFF0000 -> PortOut=0xDEADBEEF next cycle; read returns it; Hit=1.
- Read 0xFFFF0040 -> Hit=0, ReadData=0. Write to offset 0x24 -> no register changes.
- PortIn 0x00->0x05 at cycle n -> PORTIN reads 0x05 from n+2; EDGE=0x05 from n+3. With EDGE_EN=0x01, Irq=1. W1C 0x01 -> EDGE=0x04, Irq=0.
- TRELOAD=3, TCOUNT=2, TCTRL=0xB (EN, AUTO, TIE) -> TCOUNT 2,1,0. Then EXP=1 and TCOUNT=3. Irq=1 until W1C bit2.
- TCOUNT=1, TCTRL=0x1 -> after reaching 0, EXP=1, EN=0, TCOUNT stays 0. A W1C of EXP in the same cycle as the expiry -> EXP=1.
- Assert reset mid-count with PortOut=0xFF -> PortOut, TCOUNT, EDGE and Irq are 0 immediately, without waiting for clk.
- With MMIO_PORTOUT_SETCLR_EN and PORTOUT=0xF0: PORTSET 0x0F -> 0xFF; PORTCLR 0x81 -> 0x7E.
